// File: rtl/dispatch_pop_client.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_pop_client
// Description : Per-core consumer side of the hardware dispatch unit.
//               Turns a core's blocking load on the dispatch address into the
//               pop_req/pop_ack handshake with the dispatcher. It returns the
//               dispatched 32-bit value to the core and enforces the
//               dispatcher's post-ack read-pointer settling time.
//               Optional feature macro: DISPATCH_POP_TIMEOUT_EN. When it is
//               defined, a wait that lasts timeout_cycles_i cycles is aborted
//               with an error response.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i             in   1          clock
//   rst_ni            in   1          asynchronous active-low reset
//   core_req_i        in   1          core load request, held until granted
//   core_gnt_o        out  1          combinational grant
//   core_r_valid_o    out  1          one-cycle response strobe
//   core_r_data_o     out  32         dispatched value (0 on error)
//   core_r_err_o      out  1          timeout error, valid with r_valid
//   pop_req_o         out  1          one-cycle pop request to dispatcher
//   pop_ack_o         out  1          one-cycle pop acknowledge to dispatcher
//   dispatch_value_i  in   32         dispatcher's current value for this core
//   dispatch_event_i  in   1          valid value at this core's read pointer
//   timeout_cycles_i  in   TIMEOUT_W  wait limit in cycles, 0 = infinite
//   busy_o            out  1          high in every state except IDLE
// ============================================================================
module dispatch_pop_client #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 core_req_i,
  output logic                 core_gnt_o,
  output logic                 core_r_valid_o,
  output logic [31:0]          core_r_data_o,
  output logic                 core_r_err_o,
  output logic                 pop_req_o,
  output logic                 pop_ack_o,
  input  logic [31:0]          dispatch_value_i,
  input  logic                 dispatch_event_i,
  input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_COOL = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_gnt;
  logic        w_pop_req;
  logic        w_pop_ack;
  logic        w_timeout;
  logic        w_orphan;
  logic        r_valid;
  logic [31:0] r_data;
  logic        r_err;
  logic        r_busy;

`ifdef DISPATCH_POP_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] C_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_orphan;

  // The counter equals (WAIT cycles elapsed - 1), so comparing against
  // limit-1 fires in the limit-th WAIT cycle. A same-cycle event wins.
  assign w_timeout = (r_state == S_WAIT) && !dispatch_event_i &&
                     (timeout_cycles_i != '0) &&
                     (r_cnt == (timeout_cycles_i - C_ONE));
  assign w_orphan  = r_orphan;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= '0;
      r_orphan <= 1'b0;
    end else begin
      // Cleared while idle so that it reads zero on the WAIT entry cycle.
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end else if ((r_state == S_WAIT) && (r_cnt != '1)) begin
        r_cnt <= r_cnt + C_ONE;
      end
      // A timed-out pop leaves the dispatcher holding our earlier request.
      // The next grant reuses that request instead of issuing a new pop_req.
      if (w_timeout) begin
        r_orphan <= 1'b1;
      end else if ((r_state == S_IDLE) && core_req_i) begin
        r_orphan <= 1'b0;
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_orphan         = 1'b0;
  assign w_unused_timeout = ^timeout_cycles_i;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 1'b0;
    w_pop_req   = 1'b0;
    w_pop_ack   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (core_req_i) begin
          w_gnt       = 1'b1;
          w_pop_req   = !w_orphan;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dispatch_event_i) begin
          w_pop_ack   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: w_state_nxt = S_COOL;
      // COOL covers the cycle in which the dispatcher advances its read
      // pointer after clearing status on the ack.
      S_COOL: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == S_RESP);
      r_err   <= w_timeout;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_pop_ack) begin
        r_data <= dispatch_value_i;
      end else if (w_timeout) begin
        r_data <= '0;
      end
    end
  end

  // The decoded strobes are gated so every output is low while reset is held,
  // even though IDLE would otherwise grant a pending request.
  assign core_gnt_o     = w_gnt & rst_ni;
  assign pop_req_o      = w_pop_req & rst_ni;
  assign pop_ack_o      = w_pop_ack & rst_ni;
  assign core_r_valid_o = r_valid;
  assign core_r_data_o  = r_data;
  assign core_r_err_o   = r_err;
  assign busy_o         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_pop_client.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_pop_client
// Description : Self-checking bench for dispatch_pop_client. A timeline model
//               tracks grant/ack/response cycles arithmetically and checks
//               every output once per cycle, midway between clock edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_pop_client;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        core_req = 1'b0;
  logic        core_gnt;
  logic        r_valid;
  logic [31:0] r_data;
  logic        r_err;
  logic        pop_req;
  logic        pop_ack;
  logic [31:0] dval = '0;
  logic        dev = 1'b0;
  logic [15:0] tmo = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Timeline model state
  int          cyc = 0;
  int          ready_at = 0;
  int          grant_cyc = 0;
  int          resp_at = -1;
  bit          pending = 0;
  bit          orphan = 0;
  logic [31:0] resp_data = '0;
  bit          resp_err = 0;

  // Observed-event bookkeeping for directed checks
  int ack_cnt = 0;
  int popreq_cnt = 0;
  int last_ack = -1;
  int last_popreq = -1;

  dispatch_pop_client #(.TIMEOUT_W(16)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .core_req_i       (core_req),
    .core_gnt_o       (core_gnt),
    .core_r_valid_o   (r_valid),
    .core_r_data_o    (r_data),
    .core_r_err_o     (r_err),
    .pop_req_o        (pop_req),
    .pop_ack_o        (pop_ack),
    .dispatch_value_i (dval),
    .dispatch_event_i (dev),
    .timeout_cycles_i (tmo),
    .busy_o           (busy)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check all outputs against the model, then
  // advance the model and move to the next falling edge.
  task automatic step(input logic req, input logic ev, input logic [31:0] v);
    bit e_gnt, e_preq, e_ack, e_valid, e_busy, e_tmo;
    core_req = req;
    dev      = ev;
    dval     = v;
    #1;
    e_gnt   = req && !pending && (cyc >= ready_at);
    e_preq  = e_gnt && !orphan;
    e_ack   = pending && ev;
`ifdef DISPATCH_POP_TIMEOUT_EN
    e_tmo   = pending && !ev && (tmo != 16'd0) && ((cyc - grant_cyc) == int'(tmo));
`else
    e_tmo   = 1'b0;
`endif
    e_valid = (cyc == resp_at);
    e_busy  = pending || (cyc < ready_at);
    chk("gnt", {31'd0, core_gnt}, {31'd0, e_gnt});
    chk("pop_req", {31'd0, pop_req}, {31'd0, e_preq});
    chk("pop_ack", {31'd0, pop_ack}, {31'd0, e_ack});
    chk("r_valid", {31'd0, r_valid}, {31'd0, e_valid});
    chk("r_err", {31'd0, r_err}, {31'd0, e_valid && resp_err});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    if (e_valid) chk("r_data", r_data, resp_data);
    if (pop_ack) begin ack_cnt++; last_ack = cyc; end
    if (pop_req) begin popreq_cnt++; last_popreq = cyc; end
    if (e_gnt) begin
      pending   = 1;
      grant_cyc = cyc;
      orphan    = 0;
    end else if (e_ack) begin
      pending   = 0;
      resp_at   = cyc + 1;
      resp_data = v;
      resp_err  = 0;
      ready_at  = cyc + 3;
    end else if (e_tmo) begin
      pending   = 0;
      resp_at   = cyc + 1;
      resp_data = '0;
      resp_err  = 1;
      orphan    = 1;
      ready_at  = cyc + 3;
    end
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {31'd0, core_gnt}, 32'd0);
    chk({tag, "_pop_req"}, {31'd0, pop_req}, 32'd0);
    chk({tag, "_pop_ack"}, {31'd0, pop_ack}, 32'd0);
    chk({tag, "_r_valid"}, {31'd0, r_valid}, 32'd0);
    chk({tag, "_r_data"}, r_data, 32'd0);
    chk({tag, "_r_err"}, {31'd0, r_err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int a0, p0, first_ack;
    bit hold;

    // ---------------- reset state ----------------
    core_req = 1'b1;
    dev      = 1'b1;
    #2;
    chk_all_zero("reset");
    repeat (3) @(negedge clk_i);
    core_req = 1'b0;
    dev      = 1'b0;
    rst_ni   = 1'b1;

    // ---------------- event already high at grant ----------------
    a0 = ack_cnt;
    step(1'b1, 1'b1, 32'hCAFE_0001);
    chk("t1_popreq_at_grant", last_popreq, cyc - 1);
    step(1'b0, 1'b1, 32'hCAFE_0001);
    chk("t1_ack_next", last_ack, cyc - 1);
    chk("t1_resp_data", r_data, 32'hCAFE_0001);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("t1_one_ack", ack_cnt - a0, 1);

    // ---------------- event 10 cycles after grant ----------------
    a0 = ack_cnt;
    step(1'b1, 1'b0, 32'h0);
    repeat (9) step(1'b0, 1'b0, $urandom);
    step(1'b0, 1'b1, 32'h1234_5678);
    step(1'b0, 1'b1, 32'h9999_9999);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    chk("t2_one_ack", ack_cnt - a0, 1);

    // ---------------- back-to-back, request held high ----------------
    a0 = ack_cnt;
    step(1'b1, 1'b1, 32'hA000_0001);
    step(1'b1, 1'b1, 32'hA000_0002);
    first_ack = last_ack;
    p0 = popreq_cnt;
    step(1'b1, 1'b1, 32'hA000_0003);
    step(1'b1, 1'b1, 32'hA000_0004);
    chk("t3_no_early_popreq", popreq_cnt - p0, 0);
    step(1'b1, 1'b1, 32'hA000_0005);
    chk("t3_popreq_gap", last_popreq - first_ack, 3);
    step(1'b0, 1'b1, 32'hA000_0006);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    chk("t3_two_acks", ack_cnt - a0, 2);

`ifdef DISPATCH_POP_TIMEOUT_EN
    // ---------------- timeout then orphan reuse ----------------
    tmo = 16'd5;
    a0 = ack_cnt;
    step(1'b1, 1'b0, 32'h0);
    repeat (5) step(1'b0, 1'b0, 32'h0);
    chk("t4_err_resp", {31'd0, r_err}, 32'd1);
    chk("t4_err_data", r_data, 32'd0);
    chk("t4_no_ack", ack_cnt - a0, 0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    p0 = popreq_cnt;
    step(1'b1, 1'b0, 32'h0);
    chk("t4_orphan_no_popreq", popreq_cnt - p0, 0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h5555_AAAA);
    chk("t4_ok_data", r_data, 32'h5555_AAAA);
    chk("t4_ok_err", {31'd0, r_err}, 32'd0);
    repeat (3) step(1'b0, 1'b0, 32'h0);

    // ---------------- infinite wait ----------------
    tmo = 16'd0;
    step(1'b1, 1'b0, 32'h0);
    repeat (1000) step(1'b0, 1'b0, 32'h0);
    chk("t5_still_busy", {31'd0, busy}, 32'd1);
    step(1'b0, 1'b1, 32'h0BAD_F00D);
    repeat (3) step(1'b0, 1'b0, 32'h0);
`else
    // Without the feature the limit is ignored and the wait never aborts.
    tmo = 16'd5;
    step(1'b1, 1'b0, 32'h0);
    repeat (30) step(1'b0, 1'b0, 32'h0);
    chk("t4_still_busy", {31'd0, busy}, 32'd1);
    step(1'b0, 1'b1, 32'h0BAD_F00D);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    tmo = 16'd0;
`endif

    // ---------------- reset during WAIT ----------------
    step(1'b1, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    rst_ni   = 1'b0;
    core_req = 1'b1;
    dev      = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni   = 1'b1;
    pending  = 0;
    orphan   = 0;
    resp_at  = -1;
    ready_at = cyc;
    p0 = popreq_cnt;
    step(1'b1, 1'b0, 32'h0);
    chk("t6_popreq_after_rst", popreq_cnt - p0, 1);
    step(1'b0, 1'b1, 32'h7777_0000);
    repeat (3) step(1'b0, 1'b0, 32'h0);

    // ---------------- randomized traffic ----------------
    hold = 0;
    for (int blk = 0; blk < 6; blk++) begin
`ifdef DISPATCH_POP_TIMEOUT_EN
      // Change the limit only while idle so it is constant within a wait.
      while (pending || (cyc < ready_at)) step(1'b0, 1'b1, $urandom);
      tmo = 16'($urandom_range(0, 6));
`endif
      for (int i = 0; i < 400; i++) begin
        bit g;
        if (!hold) hold = ($urandom_range(0, 1) == 1);
        g = hold && !pending && (cyc >= ready_at);
        step(hold, ($urandom_range(0, 9) < 3), $urandom);
        if (g) hold = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dispatch_pop_client.md
# dispatch_pop_client

Per-core consumer side of the hardware dispatch unit: converts a core's blocking load on the dispatch address into the pop_req/pop_ack handshake with the dispatcher, and returns the dispatched 32-bit value to the core. One instance per core sits between the core's event-unit bus slave and the dispatcher's per-core pop port. It enforces the dispatcher's post-ack read-pointer settling time and optionally aborts stalled waits with an error response.

## Interface
- TIMEOUT_W, 16, width of the timeout counter and of timeout_cycles_i
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- core_req_i  in  1  core load request to dispatch address; held until granted
- core_gnt_o  out  1  grant, combinational, same cycle as accepted core_req_i
- core_r_valid_o  out  1  one-cycle response strobe
- core_r_data_o  out  32  dispatched value (0 on error)
- core_r_err_o  out  1  timeout error, valid with core_r_valid_o
- pop_req_o  out  1  one-cycle pop request to dispatcher
- pop_ack_o  out  1  one-cycle pop acknowledge to dispatcher
- dispatch_value_i  in  32  dispatcher's current value for this core
- dispatch_event_i  in  1  dispatcher flags valid value at this core's read pointer
- timeout_cycles_i  in  TIMEOUT_W  wait limit in cycles; 0 = infinite
- busy_o  out  1  high in every state except IDLE

## Operation
- States: IDLE, WAIT, RESP, COOL.
- IDLE: if core_req_i, assert core_gnt_o; if orphan flag clear, assert pop_req_o same cycle; go WAIT. If orphan set, no pop_req_o (dispatcher still holds the earlier request); clear orphan; go WAIT. dispatch_event_i ignored in IDLE.
- WAIT: when dispatch_event_i high, assert pop_ack_o this cycle, register dispatch_value_i into the response register, go RESP. Wait counter increments each WAIT cycle, saturates at all-ones, cleared on WAIT entry.
- RESP: core_r_valid_o=1 for exactly one cycle with registered data, core_r_err_o=0; go COOL.
- COOL: one idle cycle; go IDLE. No grant in RESP/COOL; core holds core_req_i.
- Outputs registered except core_gnt_o, pop_req_o, pop_ack_o (decoded from state and inputs).
- Only one request outstanding; no response buffering; core must accept core_r_valid_o unconditionally.

## Timing
- Reset: state IDLE, orphan 0, counter 0, all outputs 0.
- Grant and pop_req in cycle G; earliest pop_ack in G+1 (event sampled in WAIT).
- Ack in cycle A: core_r_valid_o in A+1, COOL A+2, earliest next pop_req A+3 (dispatcher clears status at A+1 edge and advances read pointer one cycle later).
- Best-case core latency: grant G, response G+2.
- Event and new core_req in same cycle in WAIT: event handled; request waits for IDLE.
- Reset mid-operation: immediate return to IDLE, orphan cleared; dispatcher must share rst_ni.

## Configuration
- DISPATCH_POP_TIMEOUT_EN defined: in WAIT with timeout_cycles_i != 0 and counter == timeout_cycles_i-1 and no event, go RESP with core_r_err_o=1, data 0, set orphan flag, no pop_ack_o. Event in the timeout cycle wins (normal pop).
- Not defined: counter, orphan logic removed; timeout_cycles_i ignored; core_r_err_o tied 0; WAIT exits only on event.

## Test plan
- Event already high when granted: core_req at cycle 0 -> pop_req cycle 0, pop_ack cycle 1, r_valid cycle 2 with data 0xCAFE_0001, err 0.
- Event arrives 10 cycles after grant -> pop_ack exactly one cycle, in the event's first cycle; data matches dispatch_value_i at that cycle.
- Back-to-back requests with core_req held high -> second pop_req exactly 3 cycles after first pop_ack; second grant not earlier.
- With DISPATCH_POP_TIMEOUT_EN, timeout_cycles_i=5, no event -> r_valid with err=1, data 0, 5 cycles after WAIT entry, no pop_ack; next request issues no pop_req and completes on later event with err 0.
- timeout_cycles_i=0 with macro, 1000 cycles no event -> no response, busy_o stays 1.
- rst_ni low during WAIT -> all outputs 0 immediately, busy_o 0; after release a new request issues pop_req.
